// File: rtl/lcd_sink.sv
// HD44780-style LCD bus sink: decodes 8-bit/4-bit nibble transfers, tracks the cursor
// and optionally mirrors a 2x16 display buffer (enable with macro LCD_SINK_BUFFER_EN).
module lcd_sink (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       rs,
    input  logic [3:0] data,
    output logic       byte_valid,
    output logic       byte_rs,
    output logic [7:0] byte_data,
    output logic       mode_4bit,
    output logic       sync_err,
    output logic [4:0] cursor_addr,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
);
    typedef enum logic [1:0] {S8, S4_HI, S4_LO} state_t;

    state_t     state_q, state_d;
    logic       en_q, rs_q;
    logic [3:0] data_q;
    logic [3:0] hi_q, hi_d;
    logic       hi_rs_q, hi_rs_d;
    logic       valid_q, valid_d;
    logic       brs_q, brs_d;
    logic [7:0] bdata_q, bdata_d;
    logic       eff_q, eff_d;
    logic       mode_q, mode_d;
    logic       serr_q, serr_d;
    logic [4:0] cur_q, cur_d;
    logic       fall;
    logic       cmd_clear, cmd_home, cmd_addr, dat_wr;

    assign fall = en_q & ~en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S8;
            en_q    <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= '0;
            hi_q    <= '0;
            hi_rs_q <= 1'b0;
            valid_q <= 1'b0;
            brs_q   <= 1'b0;
            bdata_q <= '0;
            eff_q   <= 1'b0;
            mode_q  <= 1'b0;
            serr_q  <= 1'b0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en;
            rs_q    <= rs;
            data_q  <= data;
            hi_q    <= hi_d;
            hi_rs_q <= hi_rs_d;
            valid_q <= valid_d;
            brs_q   <= brs_d;
            bdata_q <= bdata_d;
            eff_q   <= eff_d;
            mode_q  <= mode_d;
            serr_q  <= serr_d;
            cur_q   <= cur_d;
        end
    end

    // eff_d marks bytes that act on cursor/buffer; 8-bit-mode bytes only reach byte_*.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        hi_rs_d = hi_rs_q;
        valid_d = 1'b0;
        brs_d   = brs_q;
        bdata_d = bdata_q;
        eff_d   = 1'b0;
        mode_d  = mode_q;
        serr_d  = 1'b0;
        if (fall) begin
            case (state_q)
                S8: begin
                    valid_d = 1'b1;
                    brs_d   = rs_q;
                    bdata_d = {data_q, 4'h0};
                    if (!rs_q && data_q == 4'h2) begin
                        state_d = S4_HI;
                        mode_d  = 1'b1;
                    end
                end
                S4_HI: begin
                    hi_d    = data_q;
                    hi_rs_d = rs_q;
                    state_d = S4_LO;
                end
                S4_LO: begin
                    if (rs_q == hi_rs_q) begin
                        valid_d = 1'b1;
                        eff_d   = 1'b1;
                        brs_d   = rs_q;
                        bdata_d = {hi_q, data_q};
                        state_d = S4_HI;
                    end else begin
                        serr_d  = 1'b1;
                        hi_d    = data_q;
                        hi_rs_d = rs_q;
                    end
                end
                default: state_d = S8;
            endcase
        end
    end

    assign cmd_clear = valid_q & eff_q & ~brs_q & (bdata_q == 8'h01);
    assign cmd_home  = valid_q & eff_q & ~brs_q & (bdata_q[7:1] == 7'h01);
    assign cmd_addr  = valid_q & eff_q & ~brs_q & bdata_q[7];
    assign dat_wr    = valid_q & eff_q & brs_q;

    always_comb begin
        cur_d = cur_q;
        if (cmd_clear || cmd_home)
            cur_d = '0;
        else if (cmd_addr)
            cur_d = {bdata_q[6], bdata_q[3:0]};
        else if (dat_wr)
            cur_d = cur_q + 5'd1;
    end

`ifdef LCD_SINK_BUFFER_EN
    logic [7:0]  mem_q [32];
    logic [31:0] full_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            full_q <= '0;
        else if (cmd_clear)
            full_q <= '0;
        else if (dat_wr)
            full_q[cur_q] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (dat_wr)
            mem_q[cur_q] <= bdata_q;
    end

    assign rd_data = full_q[rd_addr] ? mem_q[rd_addr] : 8'h20;
`else
    logic unused_rd;
    assign unused_rd = ^rd_addr;
    assign rd_data   = 8'h20;
`endif

    assign byte_valid  = valid_q;
    assign byte_rs     = brs_q;
    assign byte_data   = bdata_q;
    assign mode_4bit   = mode_q;
    assign sync_err    = serr_q;
    assign cursor_addr = cur_q;
endmodule

// File: tb/tb_lcd_sink.sv
// Directed bench for lcd_sink: nibble table with expected bytes, cursor and buffer reads.
module tb_lcd_sink;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       rs = 1'b0;
    logic [3:0] data = '0;
    logic       byte_valid, byte_rs, mode_4bit, sync_err;
    logic [7:0] byte_data, rd_data;
    logic [4:0] cursor_addr;
    logic [4:0] rd_addr = '0;

    lcd_sink dut (
        .clk(clk), .reset(reset), .en(en), .rs(rs), .data(data),
        .byte_valid(byte_valid), .byte_rs(byte_rs), .byte_data(byte_data),
        .mode_4bit(mode_4bit), .sync_err(sync_err), .cursor_addr(cursor_addr),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

`ifdef LCD_SINK_BUFFER_EN
    localparam bit HAS_BUF = 1'b1;
`else
    localparam bit HAS_BUF = 1'b0;
`endif

    int         n_pass = 0;
    int         n_total = 0;
    int         nbytes = 0;
    int         nserr = 0;
    logic [7:0] last_byte = '0;
    logic       last_rs = 1'b0;

    always @(negedge clk) begin
        if (byte_valid) begin
            nbytes    <= nbytes + 1;
            last_byte <= byte_data;
            last_rs   <= byte_rs;
        end
        if (sync_err)
            nserr <= nserr + 1;
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic send_nibble(input logic r, input logic [3:0] d);
        @(posedge clk); #1;
        nbytes = 0;
        nserr  = 0;
        en = 1'b1; rs = r; data = d;
        repeat (2) @(posedge clk);
        #1 en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic       r;
        logic [3:0] n;
        logic       v;     // one byte expected from this nibble
        logic [7:0] b;     // byte_data expected afterwards (new or held)
        logic       brs;
        logic       se;
        logic       m;
        logic [4:0] cur;
        logic [4:0] ra;
        logic [7:0] rd;    // expected rd_data when the buffer is built
    } vec_t;

    vec_t tbl [27];

    initial begin
        tbl[0]  = '{1'b0, 4'h3, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 8'h20};
        tbl[1]  = '{1'b0, 4'h3, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 8'h20};
        tbl[2]  = '{1'b0, 4'h3, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00, 8'h20};
        tbl[3]  = '{1'b0, 4'h2, 1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 5'h00, 5'h00, 8'h20};
        tbl[4]  = '{1'b1, 4'h4, 1'b0, 8'h20, 1'b0, 1'b0, 1'b1, 5'h00, 5'h00, 8'h20};
        tbl[5]  = '{1'b1, 4'h8, 1'b1, 8'h48, 1'b1, 1'b0, 1'b1, 5'h01, 5'h00, 8'h48};
        tbl[6]  = '{1'b1, 4'h6, 1'b0, 8'h48, 1'b1, 1'b0, 1'b1, 5'h01, 5'h00, 8'h48};
        tbl[7]  = '{1'b1, 4'h9, 1'b1, 8'h69, 1'b1, 1'b0, 1'b1, 5'h02, 5'h01, 8'h69};
        tbl[8]  = '{1'b0, 4'hC, 1'b0, 8'h69, 1'b1, 1'b0, 1'b1, 5'h02, 5'h00, 8'h48};
        tbl[9]  = '{1'b0, 4'hF, 1'b1, 8'hCF, 1'b0, 1'b0, 1'b1, 5'h1F, 5'h01, 8'h69};
        tbl[10] = '{1'b1, 4'h4, 1'b0, 8'hCF, 1'b0, 1'b0, 1'b1, 5'h1F, 5'h1F, 8'h20};
        tbl[11] = '{1'b1, 4'h1, 1'b1, 8'h41, 1'b1, 1'b0, 1'b1, 5'h00, 5'h1F, 8'h41};
        tbl[12] = '{1'b1, 4'h4, 1'b0, 8'h41, 1'b1, 1'b0, 1'b1, 5'h00, 5'h00, 8'h48};
        tbl[13] = '{1'b1, 4'h1, 1'b1, 8'h41, 1'b1, 1'b0, 1'b1, 5'h01, 5'h00, 8'h41};
        tbl[14] = '{1'b0, 4'h0, 1'b0, 8'h41, 1'b1, 1'b0, 1'b1, 5'h01, 5'h01, 8'h69};
        tbl[15] = '{1'b0, 4'h2, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 5'h00, 5'h00, 8'h41};
        tbl[16] = '{1'b0, 4'hB, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 5'h00, 5'h00, 8'h41};
        tbl[17] = '{1'b0, 4'h5, 1'b1, 8'hB5, 1'b0, 1'b0, 1'b1, 5'h05, 5'h1F, 8'h41};
        tbl[18] = '{1'b0, 4'h0, 1'b0, 8'hB5, 1'b0, 1'b0, 1'b1, 5'h05, 5'h01, 8'h69};
        tbl[19] = '{1'b0, 4'h1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 5'h00, 5'h01, 8'h20};
        tbl[20] = '{1'b0, 4'h8, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 5'h00, 5'h00, 8'h20};
        tbl[21] = '{1'b1, 4'h5, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 5'h00, 5'h00, 8'h20};
        tbl[22] = '{1'b1, 4'hA, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 5'h01, 5'h00, 8'h5A};
        tbl[23] = '{1'b0, 4'h8, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1, 5'h01, 5'h0F, 8'h20};
        tbl[24] = '{1'b0, 4'hF, 1'b1, 8'h8F, 1'b0, 1'b0, 1'b1, 5'h0F, 5'h0F, 8'h20};
        tbl[25] = '{1'b1, 4'h3, 1'b0, 8'h8F, 1'b0, 1'b0, 1'b1, 5'h0F, 5'h0F, 8'h20};
        tbl[26] = '{1'b1, 4'h1, 1'b1, 8'h31, 1'b1, 1'b0, 1'b1, 5'h10, 5'h0F, 8'h31};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 0, byte_valid, 1'b0);
        chk("rst_data", 0, byte_data, 8'h00);
        chk("rst_rs", 0, byte_rs, 1'b0);
        chk("rst_mode", 0, mode_4bit, 1'b0);
        chk("rst_serr", 0, sync_err, 1'b0);
        chk("rst_cursor", 0, cursor_addr, 5'h00);
        chk("rst_rd", 0, rd_data, 8'h20);
        reset = 1'b0;

        for (int i = 0; i < 27; i++) begin
            send_nibble(tbl[i].r, tbl[i].n);
            chk("nbytes", i, nbytes, {31'd0, tbl[i].v});
            if (tbl[i].v) begin
                chk("pulse_byte", i, last_byte, tbl[i].b);
                chk("pulse_rs", i, last_rs, tbl[i].brs);
            end
            chk("byte_data", i, byte_data, tbl[i].b);
            chk("byte_rs", i, byte_rs, tbl[i].brs);
            chk("sync_err", i, nserr, {31'd0, tbl[i].se});
            chk("mode_4bit", i, mode_4bit, tbl[i].m);
            chk("cursor", i, cursor_addr, tbl[i].cur);
            rd_addr = tbl[i].ra;
            #1;
            chk("rd_data", i, rd_data, HAS_BUF ? tbl[i].rd : 8'h20);
        end

        // Reset while a high nibble is pending: next nibble decodes in 8-bit mode.
        send_nibble(1'b1, 4'h4);
        chk("midpair_nobyte", 0, nbytes, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        chk("midpair_mode", 0, mode_4bit, 1'b0);
        chk("midpair_cursor", 0, cursor_addr, 5'h00);
        chk("midpair_data", 0, byte_data, 8'h00);
        rd_addr = 5'h0F;
        #1;
        chk("midpair_rd", 0, rd_data, 8'h20);
        send_nibble(1'b0, 4'h3);
        chk("midpair_nbytes", 1, nbytes, 1);
        chk("midpair_byte", 1, last_byte, 8'h30);
        chk("midpair_mode", 1, mode_4bit, 1'b0);
        chk("midpair_cursor", 1, cursor_addr, 5'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 expected earlier");
        $fatal(1);
    end
endmodule

// File: doc/lcd_sink.md
LCD_SINK -- requirements
Module: lcd_sink

Interface
REQ-001 Parameter: none; geometry SHALL be fixed at 2 rows x 16 columns (32 cells).
REQ-002 clk  input  1  single system clock; all state SHALL advance on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  LCD enable strobe; a nibble is taken on its falling edge.
REQ-005 rs  input  1  register select: 0 command, 1 data.
REQ-006 data  input  4  LCD data nibble (DB7..DB4).
REQ-007 byte_valid  output  1  one-cycle strobe; a complete byte has been decoded.
REQ-008 byte_rs  output  1  rs of the decoded byte.
REQ-009 byte_data  output  8  decoded byte.
REQ-010 mode_4bit  output  1  high once the 4-bit interface switch is decoded.
REQ-011 sync_err  output  1  one-cycle strobe on nibble-pair rs mismatch.
REQ-012 cursor_addr  output  5  current cell: {row, col[3:0]}.
REQ-013 rd_addr  input  5  buffer read address.
REQ-014 rd_data  output  8  buffer contents at rd_addr, combinational.

Function
REQ-015 en, rs and data SHALL be registered once; an edge SHALL be detected when registered en=1 and input en=0, and the nibble/rs SHALL be taken from the registered copies.
REQ-016 States: S8 (8-bit mode), S4_HI (expect high nibble), S4_LO (expect low nibble); reset state S8.
REQ-017 In S8 each edge SHALL emit byte {data,4'h0} with its rs; if rs=0 and data=4'h2, next state SHALL be S4_HI and mode_4bit SHALL rise.
REQ-018 In S4_HI an edge SHALL store nibble and rs, go to S4_LO, emit nothing.
REQ-019 In S4_LO an edge with matching rs SHALL emit {hi,lo}, return to S4_HI.
REQ-020 In S4_LO an edge with mismatched rs SHALL pulse sync_err, discard the stored nibble, store the new one as high nibble, remain in S4_LO.
REQ-021 byte_valid, byte_rs, byte_data SHALL be registered and valid in the cycle after the edge cycle; byte_data/byte_rs SHALL hold until the next byte.
REQ-022 Command 8'h01 (clear) SHALL mark all 32 cells empty and set cursor_addr=0 in one cycle.
REQ-023 Commands 8'h02, 8'h03 (home) SHALL set cursor_addr=0, buffer unchanged.
REQ-024 Command with bit7=1 SHALL set cursor_addr={bit6, bits3:0}; bits5:4 ignored.
REQ-025 All other commands, including S8 bytes, SHALL affect only byte_* outputs.
REQ-026 Data byte (rs=1) SHALL write cell cursor_addr then increment cursor_addr modulo 32 (5'h0F->5'h10, 5'h1F->5'h00).
REQ-027 Command/data effects SHALL apply in the same cycle byte_valid is asserted.
REQ-028 rd_data SHALL return 8'h20 for an empty cell, else the stored byte; a write to rd_addr SHALL be visible the cycle after byte_valid.

Reset
REQ-029 Reset SHALL force: state S8, mode_4bit=0, byte_valid=0, byte_rs=0, byte_data=8'h00, sync_err=0, cursor_addr=0, all cells empty, registered en=0.
REQ-030 Reset during S4_LO SHALL discard the pending high nibble; first edge after release is decoded in S8.

Configuration
REQ-031 Macro LCD_SINK_BUFFER_EN defined: 32x8 buffer and per-cell empty flags SHALL be implemented per REQ-022, REQ-026, REQ-028.
REQ-032 Macro undefined: no storage SHALL be built; rd_data SHALL be constant 8'h20; cursor_addr behaviour unchanged.

Verification
REQ-033 Init: nibbles rs=0 3,3,3,2 -> four byte_valid pulses 8'h30,8'h30,8'h30,8'h20; mode_4bit=1 after fourth.
REQ-034 4-bit data: after init, rs=1 nibbles 4,8 then 6,9 -> bytes 8'h48, 8'h69; cursor_addr=2; rd_data(0)=8'h48, rd_data(1)=8'h69 (buffer build).
REQ-035 Address/wrap: command 8'hCF then data 8'h41 -> cell 5'h1F=8'h41, cursor_addr=5'h00.
REQ-036 Clear: after REQ-034, command 8'h01 -> rd_data(0)=8'h20, cursor_addr=0.
REQ-037 Mismatch: rs=0 nibble 8, then rs=1 nibbles 5,A -> sync_err one pulse, then byte 8'h5A rs=1.
REQ-038 Reset mid-pair: high nibble 4 sent, reset pulsed -> mode_4bit=0, next nibble 3 yields 8'h30.
